// File: rtl/mem_pkg.sv
// Shared parameters and the arbitration decision type for the memory arbiter.
package mem_pkg;

  localparam int unsigned DW_DEF       = 8;
  localparam int unsigned AW_DEF       = 10;
  localparam int unsigned WB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } arb_dec_e;

endpackage

// File: rtl/mem_arbiter_wr_fifo.sv
// Posted-write FIFO: ordered entries, head view and a per-entry address match
// vector covering only the entries valid at cycle start.
module wr_fifo
  import mem_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [AW-1:0]              head_addr,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  input  logic [AW-1:0]              match_addr,
  output logic [DEPTH-1:0]           match_vec
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == {CW{1'b0}});
  assign count     = count_q;
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      wr_ptr_d         = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // An entry is live when its distance from the read pointer is below the count.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      logic [PW-1:0] offs;
      offs = PW'(i) - rd_ptr_q;
      if (({1'b0, offs} < count_q) && (addr_q[i] == match_addr)) begin
        match_vec[i] = 1'b1;
      end else begin
        match_vec[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: one reader and one posted writer share the
// memory, at most one operation per cycle, reads first unless hazarded or full.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_rdy,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_d_i,
  input  logic [DW-1:0] mem_d_o,
  output logic          wb_empty
);

  localparam int unsigned CW = $clog2(WB_DEPTH) + 1;

  arb_dec_e              dec;
  logic                  fifo_full, fifo_empty, hazard;
  logic [AW-1:0]         head_addr;
  logic [DW-1:0]         head_data;
  logic [CW-1:0]         count;
  logic [WB_DEPTH-1:0]   match_vec;
  logic                  rd_valid_q, rd_valid_d;

  wr_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (WB_DEPTH)
  ) u_wr_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (wr_req && wr_rdy),
    .push_addr  (wr_addr),
    .push_data  (wr_data),
    .pop        (dec == DRAIN),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (count),
    .match_addr (rd_addr),
    .match_vec  (match_vec)
  );

  assign hazard   = |match_vec;
  assign wr_rdy   = !rst && !fifo_full;
  assign wb_empty = fifo_empty;

  always_comb begin
    dec = IDLE;
    if (rst) begin
      dec = IDLE;
    end else if (rd_req && !hazard && !fifo_full) begin
      dec = READ;
    end else if (!fifo_empty) begin
      dec = DRAIN;
    end else begin
      dec = IDLE;
    end
  end

  always_comb begin
    rd_gnt   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = '0;
    mem_d_i  = '0;
    case (dec)
      READ: begin
        rd_gnt   = 1'b1;
        mem_addr = rd_addr;
      end
      DRAIN: begin
        mem_wr   = 1'b1;
        mem_addr = head_addr;
        mem_d_i  = head_data;
      end
      default: begin
        rd_gnt = 1'b0;
      end
    endcase
  end

  assign rd_valid_d = rd_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_d;
    end
  end

  // A grant just before reset must not surface as valid data during reset.
  assign rd_valid = rd_valid_q && !rst;
  assign rd_data  = mem_d_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomised checks of mem_arbiter against a behavioural memory.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_rdy;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_d_i;
  logic [DW-1:0] mem_d_o;
  logic          wb_empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .AW(AW), .WB_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .rd_req   (rd_req),
    .rd_addr  (rd_addr),
    .rd_gnt   (rd_gnt),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .mem_wr   (mem_wr),
    .mem_addr (mem_addr),
    .mem_d_i  (mem_d_i),
    .mem_d_o  (mem_d_o),
    .wb_empty (wb_empty)
  );

  // Behavioural memory: unwritten words read as addr[7:0]^0xA5, read-before-write.
  logic [DW-1:0] tb_mem [1024];
  logic          tb_wrt [1024];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk) begin
    mem_d_o <= tb_wrt[mem_addr] === 1'b1 ? tb_mem[mem_addr] : init_val(mem_addr);
    if (mem_wr) begin
      tb_mem[mem_addr] <= mem_d_i;
      tb_wrt[mem_addr] <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           wq[$];
  logic [DW-1:0] ref_mem [8];
  logic          rd_pend  = 1'b0;
  logic          prev_gnt = 1'b0;
  logic [DW-1:0] exp_rd   = '0;
  int            stall    = 0;

  // One cycle of the random phase; gen=0 stops issuing new requests.
  task automatic rand_cycle(input bit gen);
    if (gen && !rd_pend && ($urandom_range(0, 1) == 1)) begin
      rd_pend = 1'b1;
      rd_addr = 10'h100 + AW'($urandom_range(0, 7));
      stall   = 0;
    end
    rd_req  = rd_pend;
    wr_req  = gen ? ($urandom_range(0, 1) == 1) : 1'b0;
    wr_addr = 10'h100 + AW'($urandom_range(0, 7));
    wr_data = DW'($urandom);
    if (rd_pend && wr_addr == rd_addr) wr_addr = {rd_addr[AW-1:3], rd_addr[2:0] + 3'd1};
    #1;
    if (prev_gnt) begin
      chk("rnd_rd_valid", rd_valid, 1);
      chk("rnd_rd_data", rd_data, exp_rd);
    end
    if (mem_wr) begin
      chk("rnd_wq_nonempty", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        chk("rnd_wr_addr", mem_addr, wq[0].a);
        chk("rnd_wr_data", mem_d_i, wq[0].d);
        void'(wq.pop_front());
      end
    end
    if (rd_gnt) begin
      exp_rd  = ref_mem[rd_addr[2:0]];
      rd_pend = 1'b0;
    end else if (rd_pend) begin
      stall++;
      chk("rnd_rd_stall_bound", stall <= 5, 1);
    end
    if (wr_req && wr_rdy) begin
      wq.push_back('{a: wr_addr, d: wr_data});
      ref_mem[wr_addr[2:0]] = wr_data;
    end
    prev_gnt = rd_gnt;
    tick();
  endtask

  initial begin
    rst = 1'b1; wr_req = 1'b1; wr_addr = 10'h005; wr_data = 8'h11;
    rd_req = 1'b1; rd_addr = 10'h005;
    tick(); #1;
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_d_i", mem_d_i, 0);
    chk("rst_wr_rdy", wr_rdy, 0);
    tick();
    rst = 1'b0; wr_req = 1'b0; rd_req = 1'b0; #1;
    chk("post_rst_wr_rdy", wr_rdy, 1);
    chk("post_rst_wb_empty", wb_empty, 1);
    chk("post_rst_rd_valid", rd_valid, 0);

    // Lone write, then read of the same address.
    wr_req = 1'b1; wr_addr = 10'h010; wr_data = 8'h5A; #1;
    chk("w1_wr_rdy", wr_rdy, 1);
    chk("w1_idle_mem_wr", mem_wr, 0);
    tick();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 10'h010; #1;
    chk("w1_hazard_gnt", rd_gnt, 0);
    chk("w1_drain_wr", mem_wr, 1);
    chk("w1_drain_addr", mem_addr, 10'h010);
    chk("w1_drain_data", mem_d_i, 8'h5A);
    chk("w1_not_empty", wb_empty, 0);
    tick(); #1;
    chk("w1_gnt", rd_gnt, 1);
    chk("w1_gnt_addr", mem_addr, 10'h010);
    chk("w1_gnt_mem_wr", mem_wr, 0);
    tick();
    rd_req = 1'b0; #1;
    chk("w1_rd_valid", rd_valid, 1);
    chk("w1_rd_data", rd_data, 8'h5A);
    tick();

    // Fill the buffer while reads hold the memory.
    rd_req = 1'b1; rd_addr = 10'h3FF;
    for (int k = 1; k <= 4; k++) begin
      wr_req = 1'b1; wr_addr = AW'(k); wr_data = 8'h10 + DW'(k); #1;
      chk("fill_gnt", rd_gnt, 1);
      chk("fill_wr_rdy", wr_rdy, 1);
      chk("fill_mem_wr", mem_wr, 0);
      if (k == 2) chk("fill_rd_data", rd_data, 8'h5A);
      tick();
    end
    wr_addr = 10'h005; wr_data = 8'hEE; #1;
    chk("full_wr_rdy", wr_rdy, 0);
    chk("full_gnt", rd_gnt, 0);
    chk("full_drain_wr", mem_wr, 1);
    chk("full_drain_addr", mem_addr, 10'h001);
    tick();
    wr_req = 1'b0; #1;
    chk("cnt3_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      #1;
      chk("drain_wr", mem_wr, 1);
      chk("drain_addr", mem_addr, AW'(k));
      chk("drain_data", mem_d_i, 8'h10 + DW'(k));
      tick();
    end
    #1;
    chk("drain_done_empty", wb_empty, 1);
    chk("drain_done_mem_wr", mem_wr, 0);

    // Read blocked by a buffered write to the same address.
    rd_req = 1'b1; rd_addr = 10'h3FF;
    wr_req = 1'b1; wr_addr = 10'h021; wr_data = 8'h11; tick();
    wr_addr = 10'h020; wr_data = 8'hC3; #1;
    chk("hz_pre_gnt", rd_gnt, 1);
    tick();
    wr_req = 1'b0; rd_addr = 10'h020; #1;
    chk("hz_gnt0_a", rd_gnt, 0);
    chk("hz_drain_a", mem_addr, 10'h021);
    tick(); #1;
    chk("hz_gnt0_b", rd_gnt, 0);
    chk("hz_drain_b", mem_addr, 10'h020);
    chk("hz_drain_b_data", mem_d_i, 8'hC3);
    tick(); #1;
    chk("hz_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0; #1;
    chk("hz_rd_data", rd_data, 8'hC3);

    // Same-cycle write and read to one address returns old contents.
    wr_req = 1'b1; wr_addr = 10'h030; wr_data = 8'h77;
    rd_req = 1'b1; rd_addr = 10'h030; #1;
    chk("sc_gnt", rd_gnt, 1);
    tick();
    wr_req = 1'b0; rd_req = 1'b0; #1;
    chk("sc_old_valid", rd_valid, 1);
    chk("sc_old_data", rd_data, 8'h95);
    chk("sc_drain_addr", mem_addr, 10'h030);
    tick();
    rd_req = 1'b1; #1;
    chk("sc_gnt2", rd_gnt, 1);
    tick();
    rd_req = 1'b0; #1;
    chk("sc_new_data", rd_data, 8'h77);

    // Reset with three entries queued and a read just granted.
    rd_req = 1'b1; rd_addr = 10'h3FF; wr_req = 1'b1;
    wr_addr = 10'h040; wr_data = 8'h01; tick();
    wr_addr = 10'h041; wr_data = 8'h02; tick();
    wr_addr = 10'h042; wr_data = 8'h03; rd_addr = 10'h3FE; #1;
    chk("rr_gnt", rd_gnt, 1);
    tick();
    rst = 1'b1; wr_req = 1'b0; rd_req = 1'b0; #1;
    chk("rr_rd_valid", rd_valid, 0);
    chk("rr_mem_wr", mem_wr, 0);
    chk("rr_wr_rdy", wr_rdy, 0);
    tick();
    rst = 1'b0; #1;
    chk("rr_empty", wb_empty, 1);
    chk("rr_wr_rdy_after", wr_rdy, 1);
    chk("rr_rd_valid_after", rd_valid, 0);
    chk("rr_mem_wr_after", mem_wr, 0);
    tick(); #1;
    chk("rr_mem_wr_after2", mem_wr, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 8; i++) ref_mem[i] = init_val(10'h100 + AW'(i));
    for (int i = 0; i < 400; i++) rand_cycle(1'b1);
    for (int i = 0; i < 12; i++) rand_cycle(1'b0);
    #1;
    chk("rnd_final_empty", wb_empty, 1);
    chk("rnd_final_wq", wq.size(), 0);
    chk("rnd_final_pend", rd_pend, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning memory data width.
REQ-002 The block SHALL have parameter AW, default 10, meaning memory address width (1024 words).
REQ-003 The block SHALL have parameter WB_DEPTH, default 4, meaning posted-write buffer depth (power of two).
REQ-004 The block SHALL have the following ports, one per line:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_req  in  1  write requester presents a write
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_rdy  out  1  write buffer can accept an entry
- rd_req  in  1  read requester presents a read
- rd_addr  in  AW  read address
- rd_gnt  out  1  read issued to memory this cycle
- rd_valid  out  1  rd_data valid (cycle after rd_gnt)
- rd_data  out  DW  read data
- mem_wr  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_d_i  out  DW  memory write data
- mem_d_o  in  DW  memory read data (registered inside memory, 1-cycle latency)
- wb_empty  out  1  write buffer holds no entries

Function
REQ-005 The block SHALL share one single-port synchronous memory between one writer and one reader, issuing at most one memory operation per cycle.
REQ-006 wr_rdy SHALL equal (count < WB_DEPTH), derived from the registered count only, never from same-cycle pops.
REQ-007 A write SHALL be accepted when wr_req && wr_rdy and pushed into the FIFO write buffer at that posedge; a write with wr_rdy=0 SHALL be ignored.
REQ-008 A read hazard SHALL exist when rd_addr equals the address of any valid buffer entry present at cycle start; same-cycle incoming writes SHALL NOT be checked.
REQ-009 Arbitration each cycle: read when rd_req && !hazard && count < WB_DEPTH; otherwise drain the head entry when count > 0; otherwise idle.
REQ-010 rd_gnt SHALL be combinational and asserted only in read cycles; the reader SHALL hold rd_req/rd_addr until rd_gnt.
REQ-011 Read cycles SHALL drive mem_wr=0, mem_addr=rd_addr; drain cycles SHALL drive mem_wr=1, mem_addr/mem_d_i from the head entry and pop it at the posedge; idle cycles SHALL drive mem_wr=0, mem_addr=0, mem_d_i=0.
REQ-012 rd_valid SHALL be rd_gnt registered by one cycle; rd_data SHALL equal mem_d_o (total read latency 1 cycle after grant).
REQ-013 A read granted in the same cycle that a write to the same address is accepted SHALL return the pre-write memory contents.
REQ-014 Simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo WB_DEPTH.
REQ-015 When full, the buffer SHALL drain one entry per cycle regardless of rd_req, so a hazarded or blocked read is granted within WB_DEPTH cycles.
REQ-016 Writes SHALL reach memory in acceptance order.
REQ-017 wb_empty SHALL equal (count == 0).

Reset
REQ-018 While rst=1 at a posedge: count, pointers, rd_valid SHALL clear to 0; pending buffer entries SHALL be discarded.
REQ-019 During reset cycles rd_gnt=0, mem_wr=0, mem_addr=0, mem_d_i=0, wr_rdy=0; after reset wr_rdy=1, wb_empty=1.
REQ-020 A read granted the cycle before reset assertion SHALL NOT produce rd_valid.

Structure
REQ-021 DW, AW, WB_DEPTH defaults and the arbitration decision enum (IDLE, READ, DRAIN) SHALL live in a shared package mem_pkg.
REQ-022 The write buffer SHALL be a sub-module wr_fifo (push, pop, head, full/empty, per-entry address match vector); the memory itself stays outside this block.

Verification
REQ-023 Write 0x5A to 0x010 alone, then read 0x010 -> drain in cycle after accept, rd_gnt one cycle later, rd_valid with rd_data=0x5A next cycle.
REQ-024 Push 4 writes (addr 0x001-0x004) with rd_req held to 0x3FF -> wr_rdy=0 at count 4, buffer drains, read granted only once count<4.
REQ-025 Buffer holds write 0x0C3->addr 0x020; read 0x020 -> rd_gnt=0 until that entry drains, then rd_data=0xC3.
REQ-026 Same cycle: accept write 0x77->0x030 and grant read 0x030 (empty buffer) -> rd_data=old value; subsequent read returns 0x77.
REQ-027 Pulse rst with 3 entries buffered and a read just granted -> no rd_valid, no mem_wr after reset, wb_empty=1, wr_rdy=1.
REQ-028 Random back-to-back writes/reads vs. reference model -> memory order and all rd_data match; wrap-around of pointers exercised.
